// File: rtl/dma_host_pkg.sv
// Shared types and helpers for the DMA host responder.
// Holds the FSM state enum, the queued request record, the last-beat
// byte-enable helper and the address-derived payload pattern.
package dma_host_pkg;

    localparam int unsigned VADDR_W  = 48;
    localparam int unsigned LEN_W    = 28;
    localparam int unsigned LEN_W1   = LEN_W + 1;
    // Widest keep vector the helper can produce (1024-bit streams).
    localparam int unsigned MAX_KEEP = 128;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SRC,
        SNK,
        CPL
    } state_t;

    typedef struct packed {
        logic               d2h;
        logic [VADDR_W-1:0] addr;
        logic [LEN_W-1:0]   len;
    } dma_req_t;

    // Byte enables of the final beat of a len-byte transfer.
    function automatic logic [MAX_KEEP-1:0] lastkeep(input logic [LEN_W-1:0] len,
                                                     input int unsigned keep_w);
        int unsigned rem;
        rem = 32'(len) % keep_w;
        if (rem == 0) begin
            lastkeep = (MAX_KEEP'(1) << keep_w) - MAX_KEEP'(1);
        end else begin
            lastkeep = (MAX_KEEP'(1) << rem) - MAX_KEEP'(1);
        end
    endfunction

    // 64-bit lane value for a given beat; wraps modulo 2^64.
    function automatic logic [63:0] pattern(input logic [VADDR_W-1:0] addr,
                                            input logic [LEN_W1-1:0] beat,
                                            input int unsigned keep_w);
        pattern = 64'(addr) + 64'(beat) * 64'(keep_w);
    endfunction

endpackage

// File: rtl/dma_req_fifo.sv
// Synchronous FIFO of DMA request records.
// Ports: aclk/areset (sync active-high), push/wdata, pop/rdata (show-ahead),
// full, empty, count. Push while full is accepted only with a same-cycle pop.
module dma_req_fifo
    import dma_host_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       push,
    input  dma_req_t                   wdata,
    input  logic                       pop,
    output dma_req_t                   rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    dma_req_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage is not reset; only pointers and count are.
    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dma_host_responder.sv
// Host-side responder for the DMA engine.
// Queues requests (req_*), sources an address-derived payload on h2d_* for
// host-to-device requests, sinks and checks d2h_* for device-to-host requests,
// and emits one completion (cpl_*) per request in order. busy is high while a
// request is queued or in progress. Sync active-high reset on areset.
module dma_host_responder
    import dma_host_pkg::*;
#(
    parameter int unsigned AXI_DATA_BITS = 512,
    parameter int unsigned KEEP_WIDTH    = AXI_DATA_BITS / 8,
    parameter int unsigned VADDR_BITS    = VADDR_W,
    parameter int unsigned LEN_BITS      = LEN_W,
    parameter int unsigned REQ_DEPTH     = 4
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_d2h,
    input  logic [VADDR_BITS-1:0]    req_addr,
    input  logic [LEN_BITS-1:0]      req_len,
    output logic [AXI_DATA_BITS-1:0] h2d_tdata,
    output logic [KEEP_WIDTH-1:0]    h2d_tkeep,
    output logic                     h2d_tvalid,
    input  logic                     h2d_tready,
    output logic                     h2d_tlast,
    input  logic [AXI_DATA_BITS-1:0] d2h_tdata,
    input  logic [KEEP_WIDTH-1:0]    d2h_tkeep,
    input  logic                     d2h_tvalid,
    output logic                     d2h_tready,
    input  logic                     d2h_tlast,
    output logic                     cpl_valid,
    input  logic                     cpl_ready,
    output logic                     cpl_d2h,
    output logic [LEN_BITS-1:0]      cpl_len,
    output logic                     cpl_err,
    output logic                     busy
);

    localparam int unsigned NLANES    = AXI_DATA_BITS / 64;
    localparam int unsigned CNT_BITS  = LEN_BITS + 1;
    localparam int unsigned FCNT_BITS = $clog2(REQ_DEPTH) + 1;

    state_t                  state, state_nxt;
    logic                    cur_d2h, cur_d2h_nxt;
    logic [VADDR_BITS-1:0]   cur_addr, cur_addr_nxt;
    logic [CNT_BITS-1:0]     last_idx, last_idx_nxt;
    logic [KEEP_WIDTH-1:0]   last_keep, last_keep_nxt;
    logic [CNT_BITS-1:0]     beat_cnt, beat_cnt_nxt;
    logic [LEN_BITS-1:0]     byte_cnt, byte_cnt_nxt;
    logic                    err, err_nxt;

    dma_req_t                fifo_wdata;
    dma_req_t                fifo_rdata;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [FCNT_BITS-1:0]    fifo_count;

    logic [LEN_BITS-1:0]     head_len;
    logic [CNT_BITS-1:0]     nbeats;
    logic                    is_last_beat;
    logic [KEEP_WIDTH-1:0]   src_keep;
    logic [63:0]             src_word;

    function automatic logic [LEN_BITS-1:0] popcount(input logic [KEEP_WIDTH-1:0] k);
        logic [LEN_BITS-1:0] n;
        n = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            n = n + LEN_BITS'(k[i]);
        end
        return n;
    endfunction

    // Byte counter saturates instead of wrapping during long drains.
    function automatic logic [LEN_BITS-1:0] sat_add(input logic [LEN_BITS-1:0] a,
                                                    input logic [LEN_BITS-1:0] b);
        logic [LEN_BITS:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[LEN_BITS] ? '1 : sum[LEN_BITS-1:0];
    endfunction

    function automatic logic [CNT_BITS-1:0] beat_inc(input logic [CNT_BITS-1:0] c);
        return (c == '1) ? c : c + CNT_BITS'(1);
    endfunction

    // Request queue
    assign req_ready  = !fifo_full;
    assign fifo_push  = req_valid && req_ready;
    assign fifo_wdata = '{d2h: req_d2h, addr: VADDR_W'(req_addr), len: LEN_W'(req_len)};

    dma_req_fifo #(
        .DEPTH (REQ_DEPTH)
    ) u_fifo (
        .aclk   (aclk),
        .areset (areset),
        .push   (fifo_push),
        .wdata  (fifo_wdata),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Transfer geometry of the queue head, consumed in LOAD.
    assign head_len = LEN_BITS'(fifo_rdata.len);
    assign nbeats   = (CNT_BITS'(head_len) + CNT_BITS'(KEEP_WIDTH - 1)) / CNT_BITS'(KEEP_WIDTH);

    // Source beat content is a pure function of registers, so it holds under stall.
    assign is_last_beat = (beat_cnt == last_idx);
    assign src_keep     = is_last_beat ? last_keep : '1;
    assign src_word     = pattern(VADDR_W'(cur_addr), LEN_W1'(beat_cnt), KEEP_WIDTH);

    assign h2d_tdata = (state == SRC) ? AXI_DATA_BITS'({NLANES{src_word}}) : '0;
    assign h2d_tkeep = (state == SRC) ? src_keep : '0;
    assign h2d_tlast = (state == SRC) && is_last_beat;

    assign cpl_d2h = cur_d2h;
    assign cpl_len = byte_cnt;
    assign cpl_err = err;
    assign busy    = (state != IDLE) || (fifo_count != '0);

    // Next-state, datapath updates and state-decoded strobes
    always_comb begin
        state_nxt     = state;
        cur_d2h_nxt   = cur_d2h;
        cur_addr_nxt  = cur_addr;
        last_idx_nxt  = last_idx;
        last_keep_nxt = last_keep;
        beat_cnt_nxt  = beat_cnt;
        byte_cnt_nxt  = byte_cnt;
        err_nxt       = err;
        fifo_pop      = 1'b0;
        h2d_tvalid    = 1'b0;
        d2h_tready    = 1'b0;
        cpl_valid     = 1'b0;

        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = LOAD;
                end
            end

            LOAD: begin
                fifo_pop      = 1'b1;
                cur_d2h_nxt   = fifo_rdata.d2h;
                cur_addr_nxt  = VADDR_BITS'(fifo_rdata.addr);
                last_idx_nxt  = nbeats - CNT_BITS'(1);
                last_keep_nxt = KEEP_WIDTH'(lastkeep(fifo_rdata.len, KEEP_WIDTH));
                beat_cnt_nxt  = '0;
                byte_cnt_nxt  = '0;
                err_nxt       = 1'b0;
                if (head_len == '0) begin
                    err_nxt   = 1'b1;
                    state_nxt = CPL;
                end else if (fifo_rdata.d2h) begin
                    state_nxt = SNK;
                end else begin
                    state_nxt = SRC;
                end
            end

            SRC: begin
                h2d_tvalid = 1'b1;
                if (h2d_tready) begin
                    beat_cnt_nxt = beat_inc(beat_cnt);
                    byte_cnt_nxt = sat_add(byte_cnt, popcount(src_keep));
                    if (is_last_beat) begin
                        state_nxt = CPL;
                    end
                end
            end

            SNK: begin
                d2h_tready = 1'b1;
                if (d2h_tvalid) begin
                    beat_cnt_nxt = beat_inc(beat_cnt);
                    byte_cnt_nxt = sat_add(byte_cnt, popcount(d2h_tkeep));
                    if (d2h_tlast) begin
                        state_nxt = CPL;
                        if (beat_cnt < last_idx) begin
                            err_nxt = 1'b1;
                        end else if (is_last_beat && (d2h_tkeep != last_keep)) begin
                            err_nxt = 1'b1;
                        end
                    end else if (is_last_beat) begin
                        // Missing tlast: flag and keep draining until it arrives.
                        err_nxt = 1'b1;
                    end
                end
            end

            CPL: begin
                cpl_valid = 1'b1;
                if (cpl_ready) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= IDLE;
            cur_d2h   <= 1'b0;
            cur_addr  <= '0;
            last_idx  <= '0;
            last_keep <= '0;
            beat_cnt  <= '0;
            byte_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_d2h   <= cur_d2h_nxt;
            cur_addr  <= cur_addr_nxt;
            last_idx  <= last_idx_nxt;
            last_keep <= last_keep_nxt;
            beat_cnt  <= beat_cnt_nxt;
            byte_cnt  <= byte_cnt_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_dma_host_responder.sv
// Bench for dma_host_responder: table of requests with engine behaviour and
// expected completions, plus hand-written sequences for queue fill/ordering
// and reset mid-transfer. Expected completions flow through a scoreboard queue.
module tb_dma_host_responder;

    localparam int unsigned DW      = 512;
    localparam int unsigned KW      = DW / 8;
    localparam int unsigned AW      = 48;
    localparam int unsigned LW      = 28;
    localparam int          TIMEOUT = 64;
    localparam logic [63:0] ALL1    = 64'hFFFF_FFFF_FFFF_FFFF;

    logic          aclk = 1'b0;
    logic          areset;
    logic          req_valid;
    logic          req_ready;
    logic          req_d2h;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;
    logic [DW-1:0] h2d_tdata;
    logic [KW-1:0] h2d_tkeep;
    logic          h2d_tvalid;
    logic          h2d_tready;
    logic          h2d_tlast;
    logic [DW-1:0] d2h_tdata;
    logic [KW-1:0] d2h_tkeep;
    logic          d2h_tvalid;
    logic          d2h_tready;
    logic          d2h_tlast;
    logic          cpl_valid;
    logic          cpl_ready;
    logic          cpl_d2h;
    logic [LW-1:0] cpl_len;
    logic          cpl_err;
    logic          busy;

    always #5 aclk = ~aclk;

    dma_host_responder dut (
        .aclk       (aclk),
        .areset     (areset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_d2h    (req_d2h),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .h2d_tdata  (h2d_tdata),
        .h2d_tkeep  (h2d_tkeep),
        .h2d_tvalid (h2d_tvalid),
        .h2d_tready (h2d_tready),
        .h2d_tlast  (h2d_tlast),
        .d2h_tdata  (d2h_tdata),
        .d2h_tkeep  (d2h_tkeep),
        .d2h_tvalid (d2h_tvalid),
        .d2h_tready (d2h_tready),
        .d2h_tlast  (d2h_tlast),
        .cpl_valid  (cpl_valid),
        .cpl_ready  (cpl_ready),
        .cpl_d2h    (cpl_d2h),
        .cpl_len    (cpl_len),
        .cpl_err    (cpl_err),
        .busy       (busy)
    );

    typedef struct {
        logic          d2h;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        int            n_send;      // engine beats sent (d2h)
        int            tlast_at;    // beat index carrying tlast (d2h)
        logic [63:0]   snd_keep;    // tkeep of last sent beat (d2h)
        int            stall_beat;  // h2d beat held with tready=0 for a cycle
        int            exp_beats;   // h2d beats expected
        logic [63:0]   exp_lkeep;   // h2d final-beat tkeep expected
        logic [LW-1:0] exp_cpl_len;
        logic          exp_err;
    } vec_t;

    typedef struct packed {
        logic          d2h;
        logic [LW-1:0] len;
        logic          err;
    } cpl_t;

    vec_t vecs [9];
    cpl_t exp_q [$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_req(input logic d2h, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_d2h   = d2h;
        req_addr  = addr;
        req_len   = len;
        while (!req_ready && n < TIMEOUT) begin
            step();
            n++;
        end
        check("req_ready_wait", DW'(req_ready), DW'(1));
        step();
        req_valid = 1'b0;
    endtask

    task automatic h2d_run(input string tag, input logic [AW-1:0] addr, input int nbeats,
                           input logic [63:0] lkeep, input int stall_beat);
        int            n;
        logic [63:0]   v;
        logic [DW-1:0] exp_data;
        logic [KW-1:0] exp_keep;
        n = 0;
        h2d_tready = 1'b0;
        while (!h2d_tvalid && n < TIMEOUT) begin
            step();
            n++;
        end
        check({tag, "_tvalid_seen"}, DW'(h2d_tvalid), DW'(1));
        check({tag, "_first_beat_latency"}, DW'(n), DW'(2));
        for (int b = 0; b < nbeats; b++) begin
            v        = 64'(addr) + 64'(b) * 64'(KW);
            exp_data = {(DW/64){v}};
            exp_keep = (b == nbeats - 1) ? lkeep : ALL1;
            check($sformatf("%s_b%0d_tdata", tag, b), h2d_tdata, exp_data);
            check($sformatf("%s_b%0d_tkeep", tag, b), DW'(h2d_tkeep), DW'(exp_keep));
            check($sformatf("%s_b%0d_tlast", tag, b), DW'(h2d_tlast), DW'(b == nbeats - 1));
            if (b == stall_beat) begin
                step();
                check($sformatf("%s_b%0d_hold_valid", tag, b), DW'(h2d_tvalid), DW'(1));
                check($sformatf("%s_b%0d_hold_tdata", tag, b), h2d_tdata, exp_data);
                check($sformatf("%s_b%0d_hold_tkeep", tag, b), DW'(h2d_tkeep), DW'(exp_keep));
                check($sformatf("%s_b%0d_hold_tlast", tag, b), DW'(h2d_tlast), DW'(b == nbeats - 1));
            end
            h2d_tready = 1'b1;
            step();
            h2d_tready = 1'b0;
        end
    endtask

    task automatic d2h_run(input string tag, input int n_send, input int tlast_at, input logic [63:0] last_keep);
        int n;
        for (int b = 0; b < n_send; b++) begin
            n = 0;
            d2h_tvalid = 1'b1;
            d2h_tdata  = {16{$urandom}};
            d2h_tkeep  = (b == n_send - 1) ? last_keep : ALL1;
            d2h_tlast  = (b == tlast_at);
            while (!d2h_tready && n < TIMEOUT) begin
                step();
                n++;
            end
            check($sformatf("%s_b%0d_tready_seen", tag, b), DW'(d2h_tready), DW'(1));
            step();
        end
        d2h_tvalid = 1'b0;
        d2h_tlast  = 1'b0;
    endtask

    task automatic wait_cpl(input string tag, output int beats_seen);
        cpl_t e;
        int   n;
        n          = 0;
        beats_seen = 0;
        cpl_ready  = 1'b1;
        while (!cpl_valid && n < TIMEOUT) begin
            if (h2d_tvalid) beats_seen++;
            step();
            n++;
        end
        check({tag, "_cpl_valid"}, DW'(cpl_valid), DW'(1));
        e = exp_q.pop_front();
        check({tag, "_cpl_d2h"}, DW'(cpl_d2h), DW'(e.d2h));
        check({tag, "_cpl_len"}, DW'(cpl_len), DW'(e.len));
        check({tag, "_cpl_err"}, DW'(cpl_err), DW'(e.err));
        step();
        cpl_ready = 1'b0;
    endtask

    initial begin
        int seen;
        int n;

        areset     = 1'b1;
        req_valid  = 1'b0;
        req_d2h    = 1'b0;
        req_addr   = '0;
        req_len    = '0;
        h2d_tready = 1'b0;
        d2h_tdata  = '0;
        d2h_tkeep  = '0;
        d2h_tvalid = 1'b0;
        d2h_tlast  = 1'b0;
        cpl_ready  = 1'b0;

        vecs[0] = '{d2h:1'b0, addr:48'h1000, len:28'd128, n_send:0, tlast_at:0, snd_keep:ALL1, stall_beat:-1,
                    exp_beats:2, exp_lkeep:ALL1, exp_cpl_len:28'd128, exp_err:1'b0};
        vecs[1] = '{d2h:1'b0, addr:48'h2000, len:28'd100, n_send:0, tlast_at:0, snd_keep:ALL1, stall_beat:0,
                    exp_beats:2, exp_lkeep:64'h0000_000F_FFFF_FFFF, exp_cpl_len:28'd100, exp_err:1'b0};
        vecs[2] = '{d2h:1'b1, addr:48'h4000, len:28'd192, n_send:3, tlast_at:2, snd_keep:ALL1, stall_beat:-1,
                    exp_beats:0, exp_lkeep:ALL1, exp_cpl_len:28'd192, exp_err:1'b0};
        vecs[3] = '{d2h:1'b1, addr:48'h4000, len:28'd192, n_send:2, tlast_at:1, snd_keep:ALL1, stall_beat:-1,
                    exp_beats:0, exp_lkeep:ALL1, exp_cpl_len:28'd128, exp_err:1'b1};
        vecs[4] = '{d2h:1'b1, addr:48'h5000, len:28'd64, n_send:3, tlast_at:2, snd_keep:ALL1, stall_beat:-1,
                    exp_beats:0, exp_lkeep:ALL1, exp_cpl_len:28'd192, exp_err:1'b1};
        vecs[5] = '{d2h:1'b1, addr:48'h6000, len:28'd100, n_send:2, tlast_at:1, snd_keep:64'h0000_000F_FFFF_FFFF,
                    stall_beat:-1, exp_beats:0, exp_lkeep:ALL1, exp_cpl_len:28'd100, exp_err:1'b0};
        vecs[6] = '{d2h:1'b1, addr:48'h6000, len:28'd100, n_send:2, tlast_at:1, snd_keep:ALL1, stall_beat:-1,
                    exp_beats:0, exp_lkeep:ALL1, exp_cpl_len:28'd128, exp_err:1'b1};
        vecs[7] = '{d2h:1'b0, addr:48'h7000, len:28'd0, n_send:0, tlast_at:0, snd_keep:ALL1, stall_beat:-1,
                    exp_beats:0, exp_lkeep:ALL1, exp_cpl_len:28'd0, exp_err:1'b1};
        vecs[8] = '{d2h:1'b0, addr:48'hFFFF_FFFF_FFC0, len:28'd130, n_send:0, tlast_at:0, snd_keep:ALL1,
                    stall_beat:-1, exp_beats:3, exp_lkeep:64'h3, exp_cpl_len:28'd130, exp_err:1'b0};

        // Reset values
        repeat (3) step();
        check("rst_req_ready",  DW'(req_ready),  DW'(1));
        check("rst_h2d_tvalid", DW'(h2d_tvalid), DW'(0));
        check("rst_h2d_tlast",  DW'(h2d_tlast),  DW'(0));
        check("rst_h2d_tkeep",  DW'(h2d_tkeep),  DW'(0));
        check("rst_h2d_tdata",  h2d_tdata,       DW'(0));
        check("rst_d2h_tready", DW'(d2h_tready), DW'(0));
        check("rst_cpl_valid",  DW'(cpl_valid),  DW'(0));
        check("rst_cpl_len",    DW'(cpl_len),    DW'(0));
        check("rst_cpl_err",    DW'(cpl_err),    DW'(0));
        check("rst_cpl_d2h",    DW'(cpl_d2h),    DW'(0));
        check("rst_busy",       DW'(busy),       DW'(0));
        areset = 1'b0;
        step();

        // Table-driven single transfers
        for (int i = 0; i < 9; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            send_req(vecs[i].d2h, vecs[i].addr, vecs[i].len);
            exp_q.push_back(cpl_t'{d2h: vecs[i].d2h, len: vecs[i].exp_cpl_len, err: vecs[i].exp_err});
            if (!vecs[i].d2h && vecs[i].exp_beats > 0) begin
                h2d_run(tag, vecs[i].addr, vecs[i].exp_beats, vecs[i].exp_lkeep, vecs[i].stall_beat);
            end
            if (vecs[i].d2h) begin
                d2h_run(tag, vecs[i].n_send, vecs[i].tlast_at, vecs[i].snd_keep);
            end
            wait_cpl(tag, seen);
            if (vecs[i].len == '0) begin
                check({tag, "_len0_no_beats"}, DW'(seen), DW'(0));
            end
        end

        // Fill the queue while completions are held off, then drain in order
        cpl_ready  = 1'b0;
        h2d_tready = 1'b0;
        send_req(1'b0, 48'h0,    28'd0);   exp_q.push_back(cpl_t'{d2h: 1'b0, len: 28'd0,   err: 1'b1});
        send_req(1'b0, 48'h3000, 28'd64);  exp_q.push_back(cpl_t'{d2h: 1'b0, len: 28'd64,  err: 1'b0});
        send_req(1'b1, 48'h0,    28'd0);   exp_q.push_back(cpl_t'{d2h: 1'b1, len: 28'd0,   err: 1'b1});
        send_req(1'b0, 48'h3040, 28'd100); exp_q.push_back(cpl_t'{d2h: 1'b0, len: 28'd100, err: 1'b0});
        send_req(1'b0, 48'h10,   28'd0);   exp_q.push_back(cpl_t'{d2h: 1'b0, len: 28'd0,   err: 1'b1});
        check("fill_req_ready_low", DW'(req_ready), DW'(0));
        check("fill_busy",          DW'(busy),      DW'(1));
        check("fill_cpl_valid",     DW'(cpl_valid), DW'(1));
        h2d_tready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_cpl($sformatf("fill_c%0d", k), seen);
        end
        h2d_tready = 1'b0;
        check("fill_drained_busy", DW'(busy), DW'(0));

        // Reset while sourcing beat 3 of 8
        send_req(1'b0, 48'h8000, 28'd512);
        n = 0;
        while (!h2d_tvalid && n < TIMEOUT) begin
            step();
            n++;
        end
        check("rstmid_tvalid_seen", DW'(h2d_tvalid), DW'(1));
        h2d_tready = 1'b1;
        repeat (3) step();
        h2d_tready = 1'b0;
        begin
            logic [63:0] v3;
            logic [DW-1:0] d3;
            v3 = 64'h80C0;
            d3 = {(DW/64){v3}};
            check("rstmid_beat3_tdata", h2d_tdata, d3);
        end
        areset = 1'b1;
        step();
        check("rstmid_h2d_tvalid", DW'(h2d_tvalid), DW'(0));
        check("rstmid_cpl_valid",  DW'(cpl_valid),  DW'(0));
        check("rstmid_busy",       DW'(busy),       DW'(0));
        check("rstmid_req_ready",  DW'(req_ready),  DW'(1));
        areset = 1'b0;
        step();
        send_req(1'b0, 48'h9000, 28'd128);
        exp_q.push_back(cpl_t'{d2h: 1'b0, len: 28'd128, err: 1'b0});
        h2d_run("post_rst", 48'h9000, 2, ALL1, -1);
        wait_cpl("post_rst", seen);
        check("final_busy", DW'(busy), DW'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dma_host_responder.md
Name: dma_host_responder

Overview:
- Host-side counterpart of the FPGA DMA engine: accepts Coyote DMA requests (`req`, `d2h`, `addr`, `len`) and services them on the engine's payload streams.
- h2d requests (engine reads): the block sources a deterministic address-derived payload on the engine's input stream.
- d2h requests (engine writes): the block sinks the engine's output stream, counts bytes and checks tlast placement.
- Each request ends with one completion record. Used as the memory/host model in the jigsaw_baseline sim and loopback bring-up.

Parameters:
- AXI_DATA_BITS, 512, stream data width.
- KEEP_WIDTH, AXI_DATA_BITS/8, bytes per beat.
- VADDR_BITS, 48, request address width.
- LEN_BITS, 28, request byte-length width.
- REQ_DEPTH, 4, request FIFO entries (power of 2, ≥2).

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- req_valid  in  1  DMA request strobe
- req_ready  out  1  request FIFO not full
- req_d2h  in  1  1 = device-to-host (sink), 0 = host-to-device (source)
- req_addr  in  VADDR_BITS  host virtual address
- req_len  in  LEN_BITS  transfer length in bytes
- h2d_tdata  out  AXI_DATA_BITS  payload to engine
- h2d_tkeep  out  KEEP_WIDTH  byte enables
- h2d_tvalid  out  1
- h2d_tready  in  1
- h2d_tlast  out  1
- d2h_tdata  in  AXI_DATA_BITS  payload from engine
- d2h_tkeep  in  KEEP_WIDTH
- d2h_tvalid  in  1
- d2h_tready  out  1
- d2h_tlast  in  1
- cpl_valid  out  1  completion available
- cpl_ready  in  1
- cpl_d2h  out  1  direction of the completed request
- cpl_len  out  LEN_BITS  bytes actually transferred (sum of popcount(tkeep) over accepted beats)
- cpl_err  out  1  length/tlast mismatch or zero length
- busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset (areset=1 on a clock edge): FIFO emptied; FSM=IDLE; counters 0. Outputs after reset: req_ready=1, h2d_tvalid=0, h2d_tlast=0, h2d_tkeep=0, h2d_tdata=0, d2h_tready=0, cpl_valid=0, cpl_len=0, cpl_err=0, cpl_d2h=0, busy=0. Reset mid-transfer aborts silently; no completion is issued.
- Request accept: when req_valid && req_ready, push {d2h, addr, len}.
  - req_ready = !full, combinational from the FIFO count.
  - Push and pop in the same cycle are legal when full.
- Beat count: nbeats = ceil(len/KEEP_WIDTH), computed at LOAD in LEN_BITS+1 bits.
- Last-beat keep: lastkeep = len%KEEP_WIDTH == 0 ? all ones : (1<<(len%KEEP_WIDTH))-1.
- FSM states and transitions:
  - IDLE: when the FIFO is non-empty, go to LOAD.
  - LOAD: pop the FIFO; latch d2h, addr, len; clear beat_cnt, byte_cnt and err.
    - len==0: err=1, go to CPL.
    - Otherwise go to SRC if d2h=0, SNK if d2h=1.
    - One bubble cycle; first-beat latency from req acceptance while idle is 2 cycles.
  - SRC: h2d_tvalid=1.
    - h2d_tdata = AXI_DATA_BITS/64 copies of the 64-bit value (addr + beat_cnt*KEEP_WIDTH), zero-extended.
    - h2d_tkeep = all ones, or lastkeep on the final beat.
    - h2d_tlast = (beat_cnt == nbeats-1).
    - On each handshake: beat_cnt++, byte_cnt += popcount(h2d_tkeep).
    - tdata/tkeep/tlast must hold stable while tvalid && !tready.
    - After the last handshake go to CPL.
  - SNK: d2h_tready=1. On each handshake: beat_cnt++, byte_cnt += popcount(d2h_tkeep).
    - tlast on beat < nbeats-1: err=1, go to CPL (early end).
    - tlast on beat == nbeats-1: go to CPL; err=1 if tkeep != lastkeep.
    - No tlast on beat nbeats-1: err=1, stay in SNK, draining until tlast. byte_cnt keeps counting, saturating at 2^LEN_BITS-1.
  - CPL: cpl_valid=1; cpl_len=byte_cnt, cpl_d2h and cpl_err held stable. On cpl_ready go to IDLE; a queued request enters LOAD on the next cycle.
- Ordering: completions are in strict request order; one transfer in flight at a time.
- Simultaneous events: a FIFO push during SRC/SNK/CPL is accepted normally. d2h_tready=0 outside SNK, so any engine data then stalls.
- Widths: byte_cnt is LEN_BITS wide and saturates; the address increment wraps modulo 2^64.

Decomposition:
- Package dma_host_pkg holds:
  - state enum {IDLE, LOAD, SRC, SNK, CPL};
  - typedef dma_req_t {d2h, addr, len};
  - function lastkeep(len);
  - function pattern(addr, beat).
- Sub-module dma_req_fifo: synchronous FIFO of dma_req_t with full/empty/count, same-cycle push/pop, same clock/reset.

Test Plan:
- h2d len=128, addr=0x1000 -> 2 beats; beat0 lanes = 0x1000, beat1 lanes = 0x1040; tkeep all ones; tlast on beat1; cpl_len=128, cpl_err=0.
- h2d len=100 with h2d_tready toggling 1-0-1 -> beat0 held stable across the stall; beat1 tkeep=(1<<36)-1 with tlast; cpl_len=100, err=0.
- d2h len=192, engine sends 3 full beats with tlast on beat2 -> cpl_d2h=1, cpl_len=192, err=0. Repeat with tlast on beat1 -> cpl_len=128, err=1.
- d2h len=64, engine sends 3 beats, tlast only on beat2 -> drain all 3 beats; cpl_len=192, err=1.
- Push 5 requests back-to-back (REQ_DEPTH=4) while cpl_ready=0 -> req_ready low after the FIFO fills. Completions arrive in order once cpl_ready=1. A len=0 request yields cpl_err=1, cpl_len=0, no beats.
- Assert areset mid-SRC on beat 3 of 8 -> next cycle h2d_tvalid=0, cpl_valid=0, busy=0, req_ready=1; a new request then runs from beat 0.
